bp_io_cmd_responder: RTL and testbench



---
 rtl/bp_me_pkg.sv | 58 +++++
 rtl/bp_io_responder_regfile.sv | 52 +++++
 rtl/bp_io_cmd_responder.sv | 158 +++++++++++++++
 tb/tb_bp_io_cmd_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// IO NoC definitions shared by the IO command responder and its register bank:
// header layout, opcode and size encodings, and byte-lane helpers.
package bp_me_pkg;

  localparam int io_cord_width_gp = 8;
  localparam int io_len_width_gp  = 4;
  localparam int io_addr_width_gp = 40;
  localparam int io_flit_width_gp = 64;

  typedef enum logic [1:0] {
    e_io_rd   = 2'd0,
    e_io_wr   = 2'd1,
    e_io_rsvd = 2'd2,
    e_io_err  = 2'd3
  } bp_io_opcode_e;

  typedef enum logic [1:0] {
    e_io_size_b = 2'd0,
    e_io_size_h = 2'd1,
    e_io_size_w = 2'd2,
    e_io_size_d = 2'd3
  } bp_io_size_e;

  // First declared field is the MSB; dst_cord lands in the flit LSBs.
  typedef struct packed {
    logic [io_addr_width_gp-1:0] addr;
    bp_io_size_e                 size;
    bp_io_opcode_e               opcode;
    logic [io_cord_width_gp-1:0] src_cord;
    logic [io_len_width_gp-1:0]  len;
    logic [io_cord_width_gp-1:0] dst_cord;
  } bp_io_noc_hdr_s;

  // Byte lanes of a dword touched by an access of the given size at offset off.
  function automatic logic [7:0] io_byte_mask(input bp_io_size_e size, input logic [2:0] off);
    logic [7:0] mask;
    case (size)
      e_io_size_b: mask = 8'h01 << off;
      e_io_size_h: mask = 8'h03 << off;
      e_io_size_w: mask = 8'h0F << off;
      default:     mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // An access must be naturally aligned to its own size.
  function automatic logic io_misaligned(input bp_io_size_e size, input logic [2:0] off);
    logic bad;
    case (size)
      e_io_size_b: bad = 1'b0;
      e_io_size_h: bad = off[0];
      e_io_size_w: bad = |off[1:0];
      default:     bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bp_io_responder_regfile.sv
// Bank of 64-bit registers with byte-masked write and one registered read port.
// Every register clears on reset, so the bank is built from flops.
module bp_io_responder_regfile
  import bp_me_pkg::*;
#(
  parameter int els_p   = 16,
  parameter int width_p = 64,
  parameter int lg_els_p = $clog2(els_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  w_v_i,
  input  logic [lg_els_p-1:0]   w_addr_i,
  input  logic [width_p/8-1:0]  w_mask_i,
  input  logic [width_p-1:0]    w_data_i,
  input  logic                  r_v_i,
  input  logic [lg_els_p-1:0]   r_addr_i,
  output logic [width_p-1:0]    r_data_o
);

  logic [width_p-1:0] entry_q [els_p];
  logic [width_p-1:0] r_data_reg;

  for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
    logic [width_p-1:0] entry_reg;

    // Byte-masked update of one register when the write address selects it.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        entry_reg <= '0;
      end else if (w_v_i && (w_addr_i == lg_els_p'(gi))) begin
        for (int b = 0; b < width_p/8; b++) begin
          if (w_mask_i[b]) entry_reg[8*b +: 8] <= w_data_i[8*b +: 8];
        end
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  // Registered read; output holds the last value read until the next read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data_reg <= '0;
    end else if (r_v_i) begin
      r_data_reg <= entry_q[r_addr_i];
    end
  end

  assign r_data_o = r_data_reg;

endmodule

// File: rtl/bp_io_cmd_responder.sv
// IO NoC command responder: receives one wormhole command packet at a time,
// executes it against a local register bank and returns a two-flit response.
// Optional build macro BP_IO_RESPONDER_ERR_CNT_EN adds a saturating 16-bit
// error counter on err_count_o; without it err_count_o is tied to zero.
module bp_io_cmd_responder
  import bp_me_pkg::*;
#(
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  parameter int addr_width_p = 40,
  parameter int reg_els_p    = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [cord_width_p-1:0]   my_cord_i,
  input  logic [flit_width_p+1:0]   cmd_link_i,
  output logic [flit_width_p+1:0]   cmd_link_o,
  input  logic [flit_width_p+1:0]   resp_link_i,
  output logic [flit_width_p+1:0]   resp_link_o,
  output logic [15:0]               err_count_o
);

  localparam int lg_els_lp = $clog2(reg_els_p);
  localparam logic [io_addr_width_gp-1:0] addr_lim_lp = io_addr_width_gp'(reg_els_p * 8);

  localparam logic [2:0] ST_RX_HDR  = 3'd0;
  localparam logic [2:0] ST_RX_DATA = 3'd1;
  localparam logic [2:0] ST_EXEC    = 3'd2;
  localparam logic [2:0] ST_TX_HDR  = 3'd3;
  localparam logic [2:0] ST_TX_DATA = 3'd4;

  logic [2:0]                 state_reg, state_next;
  bp_io_noc_hdr_s             hdr_reg;
  logic [io_flit_width_gp-1:0] wdata_reg;
  logic [io_len_width_gp-1:0]  cnt_reg;
  logic                       err_reg;

  logic                        cmd_v, cmd_ready, cmd_accept, resp_ready, resp_v;
  logic [io_flit_width_gp-1:0] cmd_data, resp_flit, wdata_shift, r_data;
  bp_io_noc_hdr_s              hdr_in, resp_hdr;
  logic [7:0]                  byte_mask;
  logic                        is_rd, is_wr, misaligned, exec_err, rf_w_v, rf_r_v;
  logic                        unused_link;

  assign cmd_v      = cmd_link_i[flit_width_p+1];
  assign cmd_data   = cmd_link_i[flit_width_p:1];
  assign resp_ready = resp_link_i[0];
  assign unused_link = ^{cmd_link_i[0], resp_link_i[flit_width_p+1:1]};
  assign hdr_in     = bp_io_noc_hdr_s'(cmd_data);

  assign cmd_ready  = !reset_i && ((state_reg == ST_RX_HDR) || (state_reg == ST_RX_DATA));
  assign cmd_accept = cmd_v && cmd_ready;
  assign resp_v     = !reset_i && ((state_reg == ST_TX_HDR) || (state_reg == ST_TX_DATA));

  // Command decode, evaluated against the latched header during EXEC.
  assign is_rd       = (hdr_reg.opcode == e_io_rd);
  assign is_wr       = (hdr_reg.opcode == e_io_wr);
  assign byte_mask   = io_byte_mask(hdr_reg.size, hdr_reg.addr[2:0]);
  assign misaligned  = io_misaligned(hdr_reg.size, hdr_reg.addr[2:0]);
  assign wdata_shift = wdata_reg << {hdr_reg.addr[2:0], 3'b000};
  assign exec_err    = hdr_reg.opcode[1]
                     | (hdr_reg.len != 4'd1)
                     | (hdr_reg.dst_cord != my_cord_i)
                     | (hdr_reg.addr >= addr_lim_lp)
                     | (is_wr & misaligned);
  assign rf_w_v      = (state_reg == ST_EXEC) && !exec_err && is_wr;
  assign rf_r_v      = (state_reg == ST_EXEC) && !exec_err && is_rd;

  bp_io_responder_regfile #(
    .els_p   (reg_els_p),
    .width_p (io_flit_width_gp)
  ) regfile (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .w_v_i    (rf_w_v),
    .w_addr_i (hdr_reg.addr[3 +: lg_els_lp]),
    .w_mask_i (byte_mask),
    .w_data_i (wdata_shift),
    .r_v_i    (rf_r_v),
    .r_addr_i (hdr_reg.addr[3 +: lg_els_lp]),
    .r_data_o (r_data)
  );

  // Packet sequencing: receive header and data flits, execute, send response.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RX_HDR:  if (cmd_accept) state_next = (hdr_in.len == '0) ? ST_EXEC : ST_RX_DATA;
      ST_RX_DATA: if (cmd_accept && (cnt_reg == 4'd1)) state_next = ST_EXEC;
      ST_EXEC:    state_next = ST_TX_HDR;
      ST_TX_HDR:  if (resp_ready) state_next = ST_TX_DATA;
      ST_TX_DATA: if (resp_ready) state_next = ST_RX_HDR;
      default:    state_next = ST_RX_HDR;
    endcase
  end

  // State register plus header, counter, write data and error latches.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= ST_RX_HDR;
      hdr_reg   <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_RX_HDR) && cmd_accept) begin
        hdr_reg   <= hdr_in;
        cnt_reg   <= hdr_in.len;
        wdata_reg <= '0;
      end
      if ((state_reg == ST_RX_DATA) && cmd_accept) begin
        cnt_reg <= cnt_reg - 4'd1;
        // Only the first data flit carries write data; trailing flits are dropped.
        if (cnt_reg == hdr_reg.len) wdata_reg <= cmd_data;
      end
      if (state_reg == ST_EXEC) err_reg <= exec_err;
    end
  end

  // Response header echoes addr/size and turns the packet back toward the sender.
  always_comb begin
    resp_hdr          = hdr_reg;
    resp_hdr.opcode   = err_reg ? e_io_err : hdr_reg.opcode;
    resp_hdr.src_cord = my_cord_i;
    resp_hdr.len      = 4'd1;
    resp_hdr.dst_cord = hdr_reg.src_cord;
  end

  // Outgoing flit: header, then read data (zero for writes and errors).
  always_comb begin
    resp_flit = '0;
    if (state_reg == ST_TX_HDR)  resp_flit = resp_hdr;
    if (state_reg == ST_TX_DATA) resp_flit = (is_rd && !err_reg) ? r_data : '0;
  end

  assign cmd_link_o  = {1'b0, {flit_width_p{1'b0}}, cmd_ready};
  assign resp_link_o = {resp_v, resp_flit, 1'b0};

`ifdef BP_IO_RESPONDER_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  // Count rejected commands, sticking at the maximum.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_cnt_reg <= '0;
    end else if ((state_reg == ST_EXEC) && exec_err && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_count_o = err_cnt_reg;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_io_cmd_responder.sv
// Self-checking bench for bp_io_cmd_responder: table of commands with a
// response scoreboard, plus hand-written latency, backpressure and reset cases.
module tb_bp_io_cmd_responder;

  localparam logic [7:0] MY_CORD = 8'h05;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_v = 1'b0;
  logic [63:0] cmd_data = '0;
  logic        resp_ready = 1'b1;
  logic [65:0] cmd_link_i, cmd_link_o, resp_link_i, resp_link_o;
  logic [15:0] err_count_o;
  logic        cmd_ready, resp_v;
  logic [63:0] resp_data;

  assign cmd_link_i  = {cmd_v, cmd_data, 1'b0};
  assign resp_link_i = {1'b0, 64'd0, resp_ready};
  assign cmd_ready   = cmd_link_o[0];
  assign resp_v      = resp_link_o[65];
  assign resp_data   = resp_link_o[64:1];

  always #5 clk = ~clk;

  bp_io_cmd_responder dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .my_cord_i   (MY_CORD),
    .cmd_link_i  (cmd_link_i),
    .cmd_link_o  (cmd_link_o),
    .resp_link_i (resp_link_i),
    .resp_link_o (resp_link_o),
    .err_count_o (err_count_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic [39:0] addr;
    logic [3:0]  len;
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [63:0] wdata;
    logic [1:0]  exp_op;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    logic [63:0] hdr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_errs = 0;
  logic got_hdr = 1'b0;
  logic [63:0] hdr_cap;
  vec_t vecs[17];

  function automatic logic [63:0] pack_hdr(input logic [39:0] addr, input logic [1:0] size,
      input logic [1:0] op, input logic [7:0] src, input logic [3:0] len, input logic [7:0] dst);
    return {addr, size, op, src, len, dst};
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic [39:0] addr,
      input logic [3:0] len, input logic [7:0] dst, input logic [7:0] src, input logic [63:0] wdata,
      input logic [1:0] exp_op, input logic [63:0] exp_data);
    vec_t v;
    v.op = op; v.size = size; v.addr = addr; v.len = len; v.dst = dst; v.src = src;
    v.wdata = wdata; v.exp_op = exp_op; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: collect header + data flit, pop expectation and compare.
  always @(negedge clk) begin
    if (!reset_i && resp_v && resp_ready) begin
      if (!got_hdr) begin
        hdr_cap = resp_data;
        got_hdr = 1'b1;
      end else begin
        got_hdr = 1'b0;
        $display("resp hdr=%h data=%h", hdr_cap, resp_data);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_hdr", hdr_cap, e.hdr);
          check("resp_data", resp_data, e.data);
        end
      end
    end
  end

  task automatic send_flit(input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_v = 1'b1;
    cmd_data = d;
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 cmd_v = 1'b0;
  endtask

  task automatic issue_cmd(input vec_t v);
    exp_t e;
    e.hdr  = pack_hdr(v.addr, v.size, v.exp_op, MY_CORD, 4'd1, v.src);
    e.data = v.exp_data;
    exp_q.push_back(e);
    if (v.exp_op == 2'd3) exp_errs++;
    send_flit(pack_hdr(v.addr, v.size, v.op, v.src, v.len, v.dst));
    for (int i = 0; i < int'(v.len); i++)
      send_flit(i == 0 ? v.wdata : {$urandom, $urandom});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || got_hdr) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || got_hdr) check("resp_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic check_err_count(input string name);
`ifdef BP_IO_RESPONDER_ERR_CNT_EN
    check(name, {48'd0, err_count_o}, exp_errs);
`else
    check(name, {48'd0, err_count_o}, 64'd0);
`endif
  endtask

  initial begin
    // op size addr len dst src wdata exp_op exp_data
    vecs[0]  = mk(2'd1, 2'd3, 40'h18, 4'd1, MY_CORD, 8'h12, 64'hDEADBEEF_CAFEF00D, 2'd1, 64'd0);
    vecs[1]  = mk(2'd0, 2'd3, 40'h18, 4'd1, MY_CORD, 8'h34, 64'd0, 2'd0, 64'hDEADBEEF_CAFEF00D);
    vecs[2]  = mk(2'd1, 2'd0, 40'h21, 4'd1, MY_CORD, 8'h12, 64'hAB, 2'd1, 64'd0);
    vecs[3]  = mk(2'd0, 2'd3, 40'h20, 4'd1, MY_CORD, 8'h56, 64'd0, 2'd0, 64'h0000_0000_0000_AB00);
    vecs[4]  = mk(2'd0, 2'd3, 40'h80, 4'd1, MY_CORD, 8'h12, 64'd0, 2'd3, 64'd0);
    vecs[5]  = mk(2'd1, 2'd1, 40'h23, 4'd1, MY_CORD, 8'h12, 64'h1234, 2'd3, 64'd0);
    vecs[6]  = mk(2'd2, 2'd3, 40'h20, 4'd1, MY_CORD, 8'h12, 64'hFFFF, 2'd3, 64'd0);
    vecs[7]  = mk(2'd0, 2'd3, 40'h18, 4'd1, 8'h06,   8'h12, 64'd0, 2'd3, 64'd0);
    vecs[8]  = mk(2'd1, 2'd2, 40'h44, 4'd1, MY_CORD, 8'h12, 64'h11223344, 2'd1, 64'd0);
    vecs[9]  = mk(2'd0, 2'd3, 40'h40, 4'd1, MY_CORD, 8'h12, 64'd0, 2'd0, 64'h11223344_00000000);
    vecs[10] = mk(2'd1, 2'd3, 40'h18, 4'd3, MY_CORD, 8'h12, 64'd0, 2'd3, 64'd0);
    vecs[11] = mk(2'd0, 2'd3, 40'h18, 4'd1, MY_CORD, 8'h12, 64'd0, 2'd0, 64'hDEADBEEF_CAFEF00D);
    vecs[12] = mk(2'd0, 2'd3, 40'h20, 4'd1, MY_CORD, 8'h12, 64'd0, 2'd0, 64'h0000_0000_0000_AB00);
    vecs[13] = mk(2'd0, 2'd3, 40'h18, 4'd0, MY_CORD, 8'h12, 64'd0, 2'd3, 64'd0);
    vecs[14] = mk(2'd1, 2'd0, 40'h7F, 4'd1, MY_CORD, 8'h22, 64'hEE, 2'd1, 64'd0);
    vecs[15] = mk(2'd0, 2'd3, 40'h78, 4'd1, MY_CORD, 8'h22, 64'd0, 2'd0, 64'hEE00_0000_0000_0000);
    vecs[16] = mk(2'd0, 2'd0, 40'h7F, 4'd1, MY_CORD, 8'h22, 64'd0, 2'd0, 64'hEE00_0000_0000_0000);

    // Reset: no ready, no valid, counter clear.
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("reset_resp_v", {63'd0, resp_v}, 64'd0);
    check("reset_err_count", {48'd0, err_count_o}, 64'd0);
    reset_i = 1'b0;
    #1 check("post_reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    for (int i = 0; i < 17; i++) begin
      issue_cmd(vecs[i]);
      wait_drain();
    end
    check_err_count("err_count_after_table");

    // Latency: EXEC cycle has no response and no ready, header follows next cycle.
    issue_cmd(mk(2'd0, 2'd3, 40'h40, 4'd1, MY_CORD, 8'h12, 64'd0, 2'd0, 64'h11223344_00000000));
    @(negedge clk);
    check("exec_resp_v", {63'd0, resp_v}, 64'd0);
    check("exec_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    check("hdr_latency_v", {63'd0, resp_v}, 64'd1);
    wait_drain();

    // Backpressure: header held stable, no command acceptance, then two flits back-to-back.
    resp_ready = 1'b0;
    issue_cmd(mk(2'd0, 2'd3, 40'h18, 4'd1, MY_CORD, 8'h77, 64'd0, 2'd0, 64'hDEADBEEF_CAFEF00D));
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_resp_v", {63'd0, resp_v}, 64'd1);
      check("bp_hdr_stable", resp_data, pack_hdr(40'h18, 2'd3, 2'd0, MY_CORD, 4'd1, 8'h77));
      check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("release_hdr", resp_data, pack_hdr(40'h18, 2'd3, 2'd0, MY_CORD, 4'd1, 8'h77));
    @(negedge clk);
    check("release_data_v", {63'd0, resp_v}, 64'd1);
    check("release_data", resp_data, 64'hDEADBEEF_CAFEF00D);
    wait_drain();

    // Reset in RX_DATA: packet abandoned, registers and counter cleared.
    send_flit(pack_hdr(40'h08, 2'd3, 2'd1, 8'h12, 4'd1, MY_CORD));
    @(negedge clk);
    reset_i = 1'b1;
    exp_errs = 0;
    #1 check("midreset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("midreset_resp_v", {63'd0, resp_v}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1 check("after_midreset_ready", {63'd0, cmd_ready}, 64'd1);
    for (int r = 0; r < 16; r++) begin
      issue_cmd(mk(2'd0, 2'd3, 40'(r * 8), 4'd1, MY_CORD, 8'h12, 64'd0, 2'd0, 64'd0));
      wait_drain();
    end
    check_err_count("err_count_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
